keypad_matrix_scanner: RTL

//  Parametrised successor to the fixed 4x4 keypad scanner. Drives one matrix row at a time,

---
 rtl/keypad_pkg.sv | 22 ++
 rtl/keypad_tick_gen.sv | 28 ++
 rtl/keypad_matrix_scanner.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and column-pattern helpers for the keypad matrix scanner.
// The helpers take a fixed-width bit vector, so callers zero-extend their column bus.
package keypad_pkg;

   typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} kp_state_t;

   localparam int MAX_COLS = 32;

   function automatic logic is_onehot(input logic [MAX_COLS-1:0] bits);
      return (bits != '0) && ((bits & (bits - MAX_COLS'(1))) == '0);
   endfunction

   function automatic int onehot_index(input logic [MAX_COLS-1:0] bits);
      int idx;
      idx = 0;
      for (int i = 0; i < MAX_COLS; i++) begin
         if (bits[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Free-running divider: one-clk tick every SCAN_DIV clocks, on the last count.
// Latency: tick is combinational from the counter; no backpressure.
module keypad_tick_gen #(
   parameter int SCAN_DIV = 12000
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int CW = $clog2(SCAN_DIV) + 1;
   localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Row-scanning keypad reader with press/release debounce and optional auto-repeat.
// Latency: 2-clk column sync, decisions on scan ticks, strobes one clk after the tick; no backpressure.
module keypad_matrix_scanner
   import keypad_pkg::*;
#(
   parameter int ROWS           = 4,
   parameter int COLS           = 4,
   parameter int SCAN_DIV       = 12000,
   parameter int DEBOUNCE_TICKS = 20,
   parameter int REPEAT_TICKS   = 0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [COLS-1:0]               col,
   output logic [ROWS-1:0]               row_drive,
   output logic [$clog2(ROWS*COLS)-1:0]  key_code,
   output logic                          key_valid,
   output logic                          key_release,
   output logic                          key_held
);

   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(COLS);
   localparam int KW = $clog2(ROWS*COLS);
   localparam int DW = $clog2(DEBOUNCE_TICKS) + 1;
   localparam int PW = $clog2(REPEAT_TICKS > 0 ? REPEAT_TICKS : 1) + 1;
   localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_TICKS);
   localparam logic [PW-1:0] RPT_LAST = PW'(REPEAT_TICKS);
   localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

   logic            tick;
   logic [COLS-1:0] col_meta, col_sync;
   kp_state_t       state, state_nxt;
   logic [RW-1:0]   row_idx, row_nxt, row_adv;
   logic [CW-1:0]   lat_col, lat_col_nxt, hit_col, acc_col;
   logic [DW-1:0]   deb_cnt, deb_nxt;
   logic [PW-1:0]   rpt_cnt, rpt_nxt;
   logic [KW-1:0]   code_nxt;
   logic            held_nxt;
   logic            valid_evt, release_evt;
   logic            do_accept, do_release;
   logic            key_bit, hit_onehot;
   logic [COLS-1:0] lat_onehot;

   keypad_tick_gen #(
      .SCAN_DIV (SCAN_DIV)
   ) u_tick_gen (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col_meta <= '0;
         col_sync <= '0;
      end else begin
         col_meta <= col;
         col_sync <= col_meta;
      end
   end

   assign row_drive  = ROWS'(1) << row_idx;
   assign row_adv    = (row_idx == ROW_LAST) ? '0 : row_idx + RW'(1);
   assign hit_onehot = is_onehot(MAX_COLS'(col_sync));
   assign hit_col    = CW'(onehot_index(MAX_COLS'(col_sync)));
   assign lat_onehot = COLS'(1) << lat_col;
   assign key_bit    = col_sync[lat_col];

   always_comb begin
      state_nxt   = state;
      row_nxt     = row_idx;
      lat_col_nxt = lat_col;
      deb_nxt     = deb_cnt;
      rpt_nxt     = rpt_cnt;
      code_nxt    = key_code;
      held_nxt    = key_held;
      valid_evt   = 1'b0;
      release_evt = 1'b0;
      do_accept   = 1'b0;
      do_release  = 1'b0;
      acc_col     = lat_col;

      if (tick) begin
         unique case (state)
            SCAN: begin
               if (hit_onehot) begin
                  lat_col_nxt = hit_col;
                  acc_col     = hit_col;
                  if (DEBOUNCE_TICKS == 1) begin
                     do_accept = 1'b1;
                  end else begin
                     deb_nxt   = DW'(1);
                     state_nxt = DEB_PRESS;
                  end
               end else begin
                  row_nxt = row_adv;
               end
            end
            DEB_PRESS: begin
               if (col_sync == lat_onehot) begin
                  deb_nxt = deb_cnt + DW'(1);
                  if (deb_cnt + DW'(1) == DEB_LAST) do_accept = 1'b1;
               end else begin
                  deb_nxt   = '0;
                  row_nxt   = row_adv;
                  state_nxt = SCAN;
               end
            end
            HELD: begin
               if (key_bit) begin
                  // Other bits in the locked row are deliberately ignored here.
                  if (REPEAT_TICKS > 0) begin
                     if (rpt_cnt + PW'(1) == RPT_LAST) begin
                        valid_evt = 1'b1;
                        rpt_nxt   = '0;
                     end else begin
                        rpt_nxt = rpt_cnt + PW'(1);
                     end
                  end
               end else if (DEBOUNCE_TICKS == 1) begin
                  do_release = 1'b1;
               end else begin
                  deb_nxt   = DW'(1);
                  state_nxt = DEB_REL;
               end
            end
            DEB_REL: begin
               if (!key_bit) begin
                  deb_nxt = deb_cnt + DW'(1);
                  if (deb_cnt + DW'(1) == DEB_LAST) do_release = 1'b1;
               end else begin
                  // A bounce back to pressed keeps the repeat phase.
                  state_nxt = HELD;
               end
            end
            default: state_nxt = SCAN;
         endcase

         if (do_accept) begin
            code_nxt  = KW'(row_idx) * KW'(COLS) + KW'(acc_col);
            valid_evt = 1'b1;
            held_nxt  = 1'b1;
            rpt_nxt   = '0;
            state_nxt = HELD;
         end
         if (do_release) begin
            release_evt = 1'b1;
            held_nxt    = 1'b0;
            deb_nxt     = '0;
            row_nxt     = row_adv;
            state_nxt   = SCAN;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= SCAN;
         row_idx  <= '0;
         lat_col  <= '0;
         deb_cnt  <= '0;
         rpt_cnt  <= '0;
         key_code <= '0;
         key_held <= 1'b0;
      end else if (tick) begin
         state    <= state_nxt;
         row_idx  <= row_nxt;
         lat_col  <= lat_col_nxt;
         deb_cnt  <= deb_nxt;
         rpt_cnt  <= rpt_nxt;
         key_code <= code_nxt;
         key_held <= held_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         key_valid   <= 1'b0;
         key_release <= 1'b0;
      end else begin
         key_valid   <= valid_evt;
         key_release <= release_evt;
      end
   end

endmodule
